dcache_port_arbiter: RTL and testbench
======================================

# dcache_port_arbiter

Sequencing controller for the single data-cache port. Each cycle it selects between the load-queue head (speculative load whose address is resolved) and the store-queue commit entry (store retired by commit), drives one request at a time into the D-cache, and tracks it through hit or miss completion. It returns load data to write-back and acknowledges stores to the store-queue update logic. It also squashes in-flight loads on a branch misprediction without disturbing committed stores.

## Interface
- LQ_IDX_W, 3, load-queue index width
- SQ_IDX_W, 3, store-queue index width
- DATA_W, 32, address and data width
- STARVE_LIMIT, 4, consecutive load grants allowed while a store waits (guard build only)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load_req_valid  in  1  load-queue head ready to issue
- load_req_index  in  LQ_IDX_W  load-queue slot of head
- load_req_addr  in  DATA_W  load address
- store_req_valid  in  1  committed store waiting at store commit pointer
- store_req_index  in  SQ_IDX_W  store-queue slot
- store_req_addr  in  DATA_W  store address
- store_req_data  in  DATA_W  store data
- sq_full  in  1  store queue has no free entry
- branch_miss  in  1  misprediction recovery this cycle
- dc_ready  in  1  cache accepts the presented request this cycle
- dc_done  in  1  cache completed the accepted request (hit or fill)
- dc_rdata  in  DATA_W  read data, valid with dc_done
- dc_valid  out  1  request presented to cache
- dc_mem_action  out  1  0 = READ, 1 = WRITE
- dc_addr  out  DATA_W  request address
- dc_wdata  out  DATA_W  store data
- load_grant  out  1  combinational pulse: head load taken, load queue advances read pointer
- store_grant  out  1  combinational pulse: commit store taken
- load_wb_valid  out  1  registered pulse: load data returned
- load_wb_index  out  LQ_IDX_W  slot of returned load
- load_wb_data  out  DATA_W  returned data
- store_ack  out  1  registered pulse: store written, entry freeable
- store_ack_index  out  SQ_IDX_W  slot of completed store
- busy  out  1  state != IDLE

## Operation
- States: IDLE, LOAD_WAIT, STORE_WAIT, LOAD_DRAIN.
- Arbitration happens only in IDLE. It is priority-based:
  - store wins if sq_full, or if the starvation counter equals STARVE_LIMIT;
  - otherwise load wins when load_req_valid;
  - otherwise store wins when store_req_valid.
- A load is never granted in a cycle with branch_miss high.
- On a grant, the block latches the index, address, data and action, sets dc_valid, and enters LOAD_WAIT or STORE_WAIT.
- In WAIT states, dc_valid and the payload are held stable until dc_ready is sampled high. After that, dc_valid is 0 until dc_done.
- dc_done may arrive in the same cycle as dc_ready (single-cycle hit).
- LOAD_WAIT:
  - dc_done → load_wb_valid with latched index and dc_rdata, then IDLE.
  - branch_miss before acceptance → drop dc_valid, return to IDLE, no writeback.
  - branch_miss after acceptance without dc_done → LOAD_DRAIN.
  - branch_miss together with dc_done → IDLE, writeback suppressed.
- LOAD_DRAIN: wait for dc_done, discard the data, go to IDLE.
- STORE_WAIT: branch_miss is ignored. dc_done → store_ack with latched index, then IDLE.
- Starvation counter, 3 bits, saturating:
  - increments on a load grant while store_req_valid is high;
  - clears on a store grant or when store_req_valid is low.

## Timing
- Reset: state IDLE, counter 0, every output 0.
- Grant at cycle N (combinational) → dc_valid high from N+1.
- dc_done at cycle M → load_wb_valid / store_ack high at M+1 for exactly one cycle. State is IDLE at M+1, so the next grant can occur at M+1.
- Minimum per-access occupancy is 2 cycles (hit with dc_ready and dc_done at N+1). Back-to-back grants are at N and N+2.
- Only one request is outstanding at any time. No grant is issued while busy.
- Reset asserted mid-access: return immediately to IDLE and discard the access. No ack or writeback is generated.

## Configuration
- STORE_STARVE_GUARD_EN defined: starvation counter and STARVE_LIMIT override are present.
- Undefined: no counter. Loads have strict priority, except that sq_full forces store priority. STARVE_LIMIT is unused.

## Test plan
- Reset, then load_req_valid with addr 0x100, index 2; dc_ready and dc_done at N+1 with rdata 0xDEAD → load_grant at N, dc_valid/READ at N+1, load_wb_valid index 2 data 0xDEAD at N+2, busy low at N+2.
- Load and store valid together, sq_full=0 → load granted first. Store granted at the next IDLE. store_ack carries the store index after that store's dc_done.
- Guard build: store valid and loads continuously valid → exactly 4 load grants, then a store grant. Non-guard build: the store waits until sq_full=1, then is granted.
- Load accepted (dc_ready=1), branch_miss the next cycle, dc_done 5 cycles later → LOAD_DRAIN, no load_wb_valid, busy until dc_done+1.
- Store in STORE_WAIT with a miss lasting 10 cycles, branch_miss pulsed at cycle 3 → store_ack still asserted after dc_done. dc_addr and dc_wdata stay stable until accepted.
- rst asserted while in LOAD_WAIT → outputs 0 immediately. The later dc_done produces no writeback.

Source files
------------

// File: rtl/dcache_port_arbiter.sv
// rtl/dcache_port_arbiter.sv - single D-cache port sequencer for load-queue head and committed stores
// Optional STORE_STARVE_GUARD_EN adds a saturating starvation counter that forces a waiting store after STARVE_LIMIT loads.
module dcache_port_arbiter #(
  parameter int LQ_IDX_W     = 3,
  parameter int SQ_IDX_W     = 3,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_req_valid,
  input  logic [LQ_IDX_W-1:0] load_req_index,
  input  logic [DATA_W-1:0]   load_req_addr,
  input  logic                store_req_valid,
  input  logic [SQ_IDX_W-1:0] store_req_index,
  input  logic [DATA_W-1:0]   store_req_addr,
  input  logic [DATA_W-1:0]   store_req_data,
  input  logic                sq_full,
  input  logic                branch_miss,
  input  logic                dc_ready,
  input  logic                dc_done,
  input  logic [DATA_W-1:0]   dc_rdata,
  output logic                dc_valid,
  output logic                dc_mem_action,
  output logic [DATA_W-1:0]   dc_addr,
  output logic [DATA_W-1:0]   dc_wdata,
  output logic                load_grant,
  output logic                store_grant,
  output logic                load_wb_valid,
  output logic [LQ_IDX_W-1:0] load_wb_index,
  output logic [DATA_W-1:0]   load_wb_data,
  output logic                store_ack,
  output logic [SQ_IDX_W-1:0] store_ack_index,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    LOAD_WAIT  = 2'd1,
    STORE_WAIT = 2'd2,
    LOAD_DRAIN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  dc_valid_q, dc_valid_d;
  logic                  accepted_q, accepted_d;
  logic                  action_q, action_d;
  logic [DATA_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [LQ_IDX_W-1:0]   lq_idx_q, lq_idx_d;
  logic [SQ_IDX_W-1:0]   sq_idx_q, sq_idx_d;
  logic                  wb_valid_q, wb_valid_d;
  logic [LQ_IDX_W-1:0]   wb_index_q, wb_index_d;
  logic [DATA_W-1:0]     wb_data_q, wb_data_d;
  logic                  ack_q, ack_d;
  logic [SQ_IDX_W-1:0]   ack_index_q, ack_index_d;

  logic starved;
  logic accept_now;
  logic issued;
  logic done_now;

`ifdef STORE_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;

  assign starved = (starve_q == 3'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!store_req_valid || store_grant) begin
      starve_d = 3'd0;
    end else if (load_grant && (starve_q != 3'd7)) begin
      starve_d = starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 3'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic [2:0] unused_starve_limit;

  assign unused_starve_limit = 3'(STARVE_LIMIT);
  assign starved             = 1'b0;
`endif

  // Grants are gated by rst so every output reads 0 while reset is held.
  always_comb begin
    load_grant  = 1'b0;
    store_grant = 1'b0;
    if (!rst && (state_q == IDLE)) begin
      if (store_req_valid && (sq_full || starved)) begin
        store_grant = 1'b1;
      end else if (load_req_valid && !branch_miss) begin
        load_grant = 1'b1;
      end else if (store_req_valid) begin
        store_grant = 1'b1;
      end
    end
  end

  // The cache owns the request once dc_ready is seen; dc_done may share that cycle.
  assign accept_now = dc_valid_q & dc_ready;
  assign issued     = accepted_q | accept_now;
  assign done_now   = issued & dc_done;

  always_comb begin
    state_d     = state_q;
    dc_valid_d  = dc_valid_q;
    accepted_d  = accepted_q;
    action_d    = action_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lq_idx_d    = lq_idx_q;
    sq_idx_d    = sq_idx_q;
    wb_valid_d  = 1'b0;
    wb_index_d  = wb_index_q;
    wb_data_d   = wb_data_q;
    ack_d       = 1'b0;
    ack_index_d = ack_index_q;

    case (state_q)
      IDLE: begin
        if (load_grant) begin
          state_d    = LOAD_WAIT;
          dc_valid_d = 1'b1;
          accepted_d = 1'b0;
          action_d   = 1'b0;
          addr_d     = load_req_addr;
          wdata_d    = '0;
          lq_idx_d   = load_req_index;
        end else if (store_grant) begin
          state_d    = STORE_WAIT;
          dc_valid_d = 1'b1;
          accepted_d = 1'b0;
          action_d   = 1'b1;
          addr_d     = store_req_addr;
          wdata_d    = store_req_data;
          sq_idx_d   = store_req_index;
        end
      end

      LOAD_WAIT: begin
        if (accept_now) begin
          dc_valid_d = 1'b0;
          accepted_d = 1'b1;
        end
        if (branch_miss) begin
          if (!done_now && issued) begin
            state_d = LOAD_DRAIN;
          end else begin
            state_d    = IDLE;
            dc_valid_d = 1'b0;
            accepted_d = 1'b0;
          end
        end else if (done_now) begin
          state_d    = IDLE;
          dc_valid_d = 1'b0;
          accepted_d = 1'b0;
          wb_valid_d = 1'b1;
          wb_index_d = lq_idx_q;
          wb_data_d  = dc_rdata;
        end
      end

      STORE_WAIT: begin
        if (accept_now) begin
          dc_valid_d = 1'b0;
          accepted_d = 1'b1;
        end
        if (done_now) begin
          state_d     = IDLE;
          dc_valid_d  = 1'b0;
          accepted_d  = 1'b0;
          ack_d       = 1'b1;
          ack_index_d = sq_idx_q;
        end
      end

      LOAD_DRAIN: begin
        if (dc_done) begin
          state_d    = IDLE;
          accepted_d = 1'b0;
        end
      end

      default: begin
        state_d    = IDLE;
        dc_valid_d = 1'b0;
        accepted_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      dc_valid_q  <= 1'b0;
      accepted_q  <= 1'b0;
      action_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      lq_idx_q    <= '0;
      sq_idx_q    <= '0;
      wb_valid_q  <= 1'b0;
      wb_index_q  <= '0;
      wb_data_q   <= '0;
      ack_q       <= 1'b0;
      ack_index_q <= '0;
    end else begin
      state_q     <= state_d;
      dc_valid_q  <= dc_valid_d;
      accepted_q  <= accepted_d;
      action_q    <= action_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lq_idx_q    <= lq_idx_d;
      sq_idx_q    <= sq_idx_d;
      wb_valid_q  <= wb_valid_d;
      wb_index_q  <= wb_index_d;
      wb_data_q   <= wb_data_d;
      ack_q       <= ack_d;
      ack_index_q <= ack_index_d;
    end
  end

  assign dc_valid        = dc_valid_q;
  assign dc_mem_action   = action_q;
  assign dc_addr         = addr_q;
  assign dc_wdata        = wdata_q;
  assign load_wb_valid   = wb_valid_q;
  assign load_wb_index   = wb_index_q;
  assign load_wb_data    = wb_data_q;
  assign store_ack       = ack_q;
  assign store_ack_index = ack_index_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// tb/tb_dcache_port_arbiter.sv - directed vector bench for dcache_port_arbiter
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_req_valid;
  logic [2:0]  load_req_index;
  logic [31:0] load_req_addr;
  logic        store_req_valid;
  logic [2:0]  store_req_index;
  logic [31:0] store_req_addr;
  logic [31:0] store_req_data;
  logic        sq_full;
  logic        branch_miss;
  logic        dc_ready;
  logic        dc_done;
  logic [31:0] dc_rdata;
  logic        dc_valid;
  logic        dc_mem_action;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic        load_grant;
  logic        store_grant;
  logic        load_wb_valid;
  logic [2:0]  load_wb_index;
  logic [31:0] load_wb_data;
  logic        store_ack;
  logic [2:0]  store_ack_index;
  logic        busy;

  dcache_port_arbiter #(
    .LQ_IDX_W(3), .SQ_IDX_W(3), .DATA_W(32), .STARVE_LIMIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .load_req_valid(load_req_valid), .load_req_index(load_req_index), .load_req_addr(load_req_addr),
    .store_req_valid(store_req_valid), .store_req_index(store_req_index),
    .store_req_addr(store_req_addr), .store_req_data(store_req_data),
    .sq_full(sq_full), .branch_miss(branch_miss),
    .dc_ready(dc_ready), .dc_done(dc_done), .dc_rdata(dc_rdata),
    .dc_valid(dc_valid), .dc_mem_action(dc_mem_action), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .load_grant(load_grant), .store_grant(store_grant),
    .load_wb_valid(load_wb_valid), .load_wb_index(load_wb_index), .load_wb_data(load_wb_data),
    .store_ack(store_ack), .store_ack_index(store_ack_index), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        lv;
    logic [2:0]  li;
    logic [31:0] la;
    logic        sv;
    logic [2:0]  si;
    logic [31:0] sa;
    logic [31:0] sd;
    logic        sqf;
    logic        bm;
    logic        rdy;
    logic        done;
    logic [31:0] rd;
  } in_t;

  typedef struct packed {
    logic        lg;
    logic        sg;
    logic        dv;
    logic        act;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wbv;
    logic [2:0]  wbi;
    logic [31:0] wbd;
    logic        ack;
    logic [2:0]  acki;
    logic        busy;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  o;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  vec_t tbl[16];

  task automatic drive(input in_t i);
    load_req_valid  = i.lv;
    load_req_index  = i.li;
    load_req_addr   = i.la;
    store_req_valid = i.sv;
    store_req_index = i.si;
    store_req_addr  = i.sa;
    store_req_data  = i.sd;
    sq_full         = i.sqf;
    branch_miss     = i.bm;
    dc_ready        = i.rdy;
    dc_done         = i.done;
    dc_rdata        = i.rd;
  endtask

  function automatic out_t obs();
    return '{load_grant, store_grant, dc_valid, dc_mem_action, dc_addr, dc_wdata,
             load_wb_valid, load_wb_index, load_wb_data, store_ack, store_ack_index, busy};
  endfunction

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: outputs got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] Z = 32'h0;

  initial begin
    in_t ist;
    int  n_ld;
    int  n_st;
    bit  seen;

    drive('0);

    tbl[0]  = '{"reset_idle",   in_t'('0), out_t'('0)};
    tbl[1]  = '{"ld_grant",     in_t'{1'b1, 3'd2, 32'h100, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b1, 1'b0, 1'b0, 1'b0, Z, Z, 1'b0, 3'd0, Z, 1'b0, 3'd0, 1'b0}};
    tbl[2]  = '{"ld_hit",       in_t'{1'b0, 3'd0, Z, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDEAD},
                                out_t'{1'b0, 1'b0, 1'b1, 1'b0, 32'h100, Z, 1'b0, 3'd0, Z, 1'b0, 3'd0, 1'b1}};
    tbl[3]  = '{"ld_wb",        in_t'('0),
                                out_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h100, Z, 1'b1, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b0}};
    tbl[4]  = '{"both_ld_first", in_t'{1'b1, 3'd3, 32'h200, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b1, 1'b0, 1'b0, 1'b0, 32'h100, Z, 1'b0, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b0}};
    tbl[5]  = '{"ld2_wait",     in_t'{1'b0, 3'd0, Z, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b0, 1'b0, 1'b1, 1'b0, 32'h200, Z, 1'b0, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b1}};
    tbl[6]  = '{"ld2_accept",   in_t'{1'b0, 3'd0, Z, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b1, 1'b0, Z},
                                out_t'{1'b0, 1'b0, 1'b1, 1'b0, 32'h200, Z, 1'b0, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b1}};
    tbl[7]  = '{"ld2_pending",  in_t'{1'b0, 3'd0, Z, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h200, Z, 1'b0, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b1}};
    tbl[8]  = '{"ld2_done",     in_t'{1'b0, 3'd0, Z, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234},
                                out_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h200, Z, 1'b0, 3'd2, 32'hDEAD, 1'b0, 3'd0, 1'b1}};
    tbl[9]  = '{"st_grant",     in_t'{1'b0, 3'd0, Z, 1'b1, 3'd5, 32'h300, 32'hCAFE, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b0, 1'b1, 1'b0, 1'b0, 32'h200, Z, 1'b1, 3'd3, 32'h1234, 1'b0, 3'd0, 1'b0}};
    tbl[10] = '{"st_hit",       in_t'{1'b0, 3'd0, Z, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b1, 1'b1, Z},
                                out_t'{1'b0, 1'b0, 1'b1, 1'b1, 32'h300, 32'hCAFE, 1'b0, 3'd3, 32'h1234, 1'b0, 3'd0, 1'b1}};
    tbl[11] = '{"st_ack",       in_t'('0),
                                out_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'hCAFE, 1'b0, 3'd3, 32'h1234, 1'b1, 3'd5, 1'b0}};
    tbl[12] = '{"ld_blocked_bm", in_t'{1'b1, 3'd1, 32'h800, 1'b0, 3'd0, Z, Z, 1'b0, 1'b1, 1'b0, 1'b0, Z},
                                out_t'{1'b0, 1'b0, 1'b0, 1'b1, 32'h300, 32'hCAFE, 1'b0, 3'd3, 32'h1234, 1'b0, 3'd5, 1'b0}};
    tbl[13] = '{"ld3_grant",    in_t'{1'b1, 3'd1, 32'h800, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z},
                                out_t'{1'b1, 1'b0, 1'b0, 1'b1, 32'h300, 32'hCAFE, 1'b0, 3'd3, 32'h1234, 1'b0, 3'd5, 1'b0}};
    tbl[14] = '{"ld3_bm_preacc", in_t'{1'b0, 3'd0, Z, 1'b0, 3'd0, Z, Z, 1'b0, 1'b1, 1'b0, 1'b0, Z},
                                out_t'{1'b0, 1'b0, 1'b1, 1'b0, 32'h800, Z, 1'b0, 3'd3, 32'h1234, 1'b0, 3'd5, 1'b1}};
    tbl[15] = '{"ld3_dropped",  in_t'('0),
                                out_t'{1'b0, 1'b0, 1'b0, 1'b0, 32'h800, Z, 1'b0, 3'd3, 32'h1234, 1'b0, 3'd5, 1'b0}};

    // Reset held: every output must be 0.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_out("in_reset", obs(), out_t'('0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k].i);
      @(negedge clk);
      chk_out(tbl[k].name, obs(), tbl[k].o);
      step();
    end

    // Store waiting while loads stream in back to back.
    ist = '{1'b1, 3'd1, 32'h440, 1'b1, 3'd6, 32'h400, 32'h55, 1'b0, 1'b0, 1'b1, 1'b1, 32'h9};
    drive(ist);
    n_ld = 0;
    n_st = 0;
`ifdef STORE_STARVE_GUARD_EN
    for (int c = 0; c < 40 && n_st == 0; c++) begin
      @(negedge clk);
      if (load_grant) n_ld++;
      if (store_grant) n_st++;
      step();
    end
    chk("starve_store_granted", 32'(n_st), 32'd1);
    chk("starve_loads_before", 32'(n_ld), 32'd4);
`else
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (load_grant) n_ld++;
      if (store_grant) n_st++;
      step();
    end
    chk("strict_loads", 32'(n_ld), 32'd6);
    chk("strict_no_store", 32'(n_st), 32'd0);
    sq_full = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(negedge clk);
      if (store_grant) seen = 1'b1;
      step();
    end
    chk("sqfull_store_granted", 32'(seen), 32'd1);
`endif
    store_req_valid = 1'b0;
    load_req_valid  = 1'b0;
    sq_full         = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6 && !seen; c++) begin
      @(negedge clk);
      if (store_ack) begin
        seen = 1'b1;
        chk("starve_ack_index", 32'(store_ack_index), 32'd6);
      end
      step();
    end
    chk("starve_ack_seen", 32'(seen), 32'd1);
    drive('0);
    repeat (2) step();

    // Load accepted, then branch_miss: drain and discard.
    drive('{1'b1, 3'd1, 32'h500, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z});
    @(negedge clk);
    chk("drain_grant", 32'(load_grant), 32'd1);
    step();
    load_req_valid = 1'b0;
    dc_ready = 1'b1;
    @(negedge clk);
    chk("drain_dv", 32'(dc_valid), 32'd1);
    step();
    dc_ready = 1'b0;
    branch_miss = 1'b1;
    @(negedge clk);
    chk("drain_dv_low", 32'(dc_valid), 32'd0);
    step();
    branch_miss = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      dc_done  = (k == 5);
      dc_rdata = 32'hBAD0;
      @(negedge clk);
      chk($sformatf("drain_busy_%0d", k), 32'(busy), 32'd1);
      chk($sformatf("drain_nowb_%0d", k), 32'(load_wb_valid), 32'd0);
      step();
    end
    dc_done = 1'b0;
    @(negedge clk);
    chk("drain_idle", 32'(busy), 32'd0);
    chk("drain_nowb_end", 32'(load_wb_valid), 32'd0);
    step();

    // Store miss with a stray branch_miss; payload held until accepted.
    drive('{1'b0, 3'd0, Z, 1'b1, 3'd4, 32'h600, 32'h77, 1'b0, 1'b0, 1'b0, 1'b0, Z});
    @(negedge clk);
    chk("st2_grant", 32'(store_grant), 32'd1);
    step();
    drive('{1'b1, 3'd7, 32'h700, 1'b0, 3'd0, Z, Z, 1'b0, 1'b0, 1'b0, 1'b0, Z});
    for (int w = 1; w <= 14; w++) begin
      branch_miss = (w == 3);
      dc_ready    = (w == 4);
      dc_done     = (w == 14);
      @(negedge clk);
      chk($sformatf("st2_nogrant_%0d", w), 32'(load_grant), 32'd0);
      if (w <= 4) begin
        chk($sformatf("st2_dv_%0d", w), 32'(dc_valid), 32'd1);
        chk($sformatf("st2_addr_%0d", w), dc_addr, 32'h600);
        chk($sformatf("st2_wdata_%0d", w), dc_wdata, 32'h77);
      end else begin
        chk($sformatf("st2_dvlow_%0d", w), 32'(dc_valid), 32'd0);
      end
      step();
    end
    branch_miss = 1'b0;
    dc_ready    = 1'b0;
    dc_done     = 1'b0;
    @(negedge clk);
    chk("st2_ack", 32'(store_ack), 32'd1);
    chk("st2_ack_index", 32'(store_ack_index), 32'd4);
    chk("st2_next_load_grant", 32'(load_grant), 32'd1);
    step();

    // Reset in LOAD_WAIT: outputs clear at once; later dc_done is ignored.
    load_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_dv", 32'(dc_valid), 32'd1);
    chk("rst_pre_addr", dc_addr, 32'h700);
    #1;
    rst = 1'b1;
    load_req_valid = 1'b1;
    #1;
    chk_out("rst_async_zero", obs(), out_t'('0));
    step();
    rst = 1'b0;
    load_req_valid = 1'b0;
    dc_done = 1'b1;
    dc_rdata = 32'hF00D;
    @(negedge clk);
    chk("rst_post_busy", 32'(busy), 32'd0);
    chk("rst_post_dv", 32'(dc_valid), 32'd0);
    step();
    dc_done = 1'b0;
    @(negedge clk);
    chk("rst_post_nowb", 32'(load_wb_valid), 32'd0);
    chk("rst_post_noack", 32'(store_ack), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
